// File: rtl/barcode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : barcode_pkg
//  Brief    : Shared widths, constants and FSM state type for barcode_rx.
//  Revision : 1.0 - initial release
// ============================================================================
package barcode_pkg;

    localparam int PERIOD_W = 22;
    localparam int ID_W     = 8;

    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]          BIT_LAST = 4'(ID_W - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        START       = 2'd1,
        WAIT_FALL   = 2'd2,
        WAIT_SAMPLE = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bc_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : bc_sync_edge
//  Brief    : Two-flop synchronizer for the idle-high BC line plus a
//             falling-edge detector on the synchronized level.
//  Revision : 1.0 - initial release
// ============================================================================
module bc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic bc_s,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // All flops reset high so a line idling high never produces a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bc;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign bc_s = r_sync2;
    assign fall = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/barcode_rx.sv
`default_nettype none
// ============================================================================
//  Module   : barcode_rx
//  Brief    : Self-calibrating serial barcode receiver; measures the start
//             bit, then samples each data bit half a period after its fall.
//             Optional abort timeouts enabled by `define BC_RX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module barcode_rx
    import barcode_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_vld,
    output logic            BC_err
);

    rx_state_t             r_state;
    logic [PERIOD_W-1:0]   r_cnt;
    logic [PERIOD_W-1:0]   r_half_cnt;
    logic [3:0]            r_bit_cnt;
    logic [ID_W-1:0]       r_shft;
    logic [ID_W-1:0]       r_id;
    logic                  r_id_vld;

    logic                  w_bc_s;
    logic                  w_fall;
    logic                  w_sample;

    bc_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .bc    (BC),
        .bc_s  (w_bc_s),
        .fall  (w_fall)
    );

    assign w_sample = (r_cnt == r_half_cnt);

`ifdef BC_RX_TIMEOUT_EN
    logic r_bc_err;
    logic w_cnt_sat;
    logic w_wf_timeout;

    // About two bit periods without a fall, measured from the last fall.
    assign w_cnt_sat    = (r_cnt == CNT_MAX);
    assign w_wf_timeout = ({2'b00, r_cnt} == {r_half_cnt, 2'b00}) || w_cnt_sat;
    assign BC_err       = r_bc_err;
`else
    assign BC_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shft     <= '0;
            r_id       <= '0;
            r_id_vld   <= 1'b0;
`ifdef BC_RX_TIMEOUT_EN
            r_bc_err   <= 1'b0;
`endif
        end else begin
`ifdef BC_RX_TIMEOUT_EN
            r_bc_err <= 1'b0;
`endif
            if (w_fall)
                r_cnt <= '0;
            else if (r_state != IDLE && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;

            // The load below is a later assignment, so set wins over clear.
            if (clr_ID_vld)
                r_id_vld <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_bit_cnt <= '0;
                    end
                end
                START: begin
                    if (w_bc_s) begin
                        r_half_cnt <= r_cnt;
                        r_state    <= WAIT_FALL;
                    end
`ifdef BC_RX_TIMEOUT_EN
                    else if (w_cnt_sat) begin
                        r_state  <= IDLE;
                        r_bc_err <= 1'b1;
                    end
`endif
                end
                WAIT_FALL: begin
                    if (w_fall)
                        r_state <= WAIT_SAMPLE;
`ifdef BC_RX_TIMEOUT_EN
                    else if (w_wf_timeout) begin
                        r_state  <= IDLE;
                        r_bc_err <= 1'b1;
                    end
`endif
                end
                WAIT_SAMPLE: begin
                    if (w_sample) begin
                        r_shft    <= {r_shft[ID_W-2:0], w_bc_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_id     <= {r_shft[ID_W-2:0], w_bc_s};
                            r_id_vld <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= WAIT_FALL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ID     = r_id;
    assign ID_vld = r_id_vld;

endmodule
`default_nettype wire

// File: doc/barcode_rx.md
# barcode_rx

Receives and decodes the serial station-ID barcode stream (idle-high BC line) into an 8-bit ID. Self-calibrates the bit period from the start bit, then samples each data bit at that measured half-period after its falling edge. Sits in the follower between the barcode sensor input and the command/navigation logic, which consumes `ID` on `ID_vld`. The module is the receiving end of the `barcode_mimic` transmit protocol.

## Interface
- No parameters. Width constants come from the package.
- `clk  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `BC  in  1`: raw, asynchronous barcode serial input; idles high.
- `clr_ID_vld  in  1`: consumer acknowledge; clears `ID_vld`.
- `ID  out  8`: last decoded station ID.
- `ID_vld  out  1`: a new ID is held in `ID`.
- `BC_err  out  1`: one-cycle pulse on a frame abort (see Configuration).

## Operation
- Input conditioning:
  - `BC` passes through a 2-flop synchronizer (both flops reset to 1), then a third flop.
  - `fall` = prev & ~sync.
- Protocol, per frame:
  - Start bit: BC low for P/2, then high until P.
  - 8 data bits, MSB first. Each bit begins with a fall; low for P/4 means 1, low for 3P/4 means 0.
  - P varies by ±P/32 per bit.
- Counter: 22-bit `cnt`, saturating at 22'h3FFFFF. Cleared on every `fall`; increments otherwise in all states except IDLE.
- `half_cnt`: 22-bit register capturing the start-bit low duration.
- `bit_cnt`: 4-bit counter.
- `shft`: 8-bit shift register; shifts in at bit 0, i.e. `{shft[6:0], sample}`.
- States and transitions:
  - **IDLE**: on `fall` → START; clear `cnt`; clear `bit_cnt`.
  - **START**: on rising sync BC, capture `half_cnt <= cnt`, then → WAIT_FALL.
  - **WAIT_FALL**: on `fall` → WAIT_SAMPLE, with `cnt` cleared.
  - **WAIT_SAMPLE**:
    - When `cnt == half_cnt`: shift in sync BC and increment `bit_cnt`.
    - If `bit_cnt` was 7: → IDLE and assert load, so `ID <= {shft[6:0], sample}` and `ID_vld` is set.
    - Otherwise → WAIT_FALL.
- `ID_vld` is a set/clear flop; set has priority over `clr_ID_vld` in the same cycle.
- `ID` holds its value until the next complete frame. An aborted frame never modifies `ID` or `ID_vld`.
- A `fall` in WAIT_SAMPLE before the sample point is ignored; only the counter compare advances the state.

## Timing
- Reset values:
  - `ID` = 8'h00, `ID_vld` = 0, `BC_err` = 0, state = IDLE.
  - Synchronizer flops = 1, `cnt` = 0, `half_cnt` = 0.
- Reset asserted mid-frame returns to IDLE immediately (asynchronously). Partial data is discarded.
- Input-to-`fall` latency: 2–3 clk from the BC edge.
- Sample point: `half_cnt` + 1 clk after `fall` is detected. This is ≈P/2 into the bit, with ≥P/4 − P/32 margin on either side.
- `ID_vld` rises 1 clk after the 8th sample, i.e. ≈P/2 after the last bit's fall.
- Back-to-back frames: a new frame's start `fall` is accepted in the first IDLE cycle after load.
- Zero-length start bit: `half_cnt` = 0 is legal. Samples are then taken 1 clk after each fall.

## Configuration
- Macro: `BC_RX_TIMEOUT_EN`.
- Defined — abort conditions:
  - START aborts when `cnt` saturates.
  - WAIT_FALL aborts when `{2'b00,cnt} == {half_cnt,2'b00}` (≈2P with no fall) or when `cnt` saturates.
  - On abort: → IDLE and pulse `BC_err` high for exactly 1 clk.
- Not defined: no timeouts (states wait indefinitely), and `BC_err` is tied 0.

## Structure
- Package `barcode_pkg`:
  - state enum `rx_state_t` (IDLE, START, WAIT_FALL, WAIT_SAMPLE);
  - `PERIOD_W` = 22;
  - `ID_W` = 8.
- One sub-module: `bc_sync_edge`, containing the 2-flop synchronizer, the edge-detect flop, and outputs `bc_s` and `fall`.

## Test plan
- **Basic decode**: `barcode_mimic`, period 22'd1024, ID 8'hA5 → `ID` = 8'hA5 and `ID_vld` = 1 within 600 clk after the transmitter's `BC_done`; `BC_err` stays 0.
- **Extremes, back-to-back**: IDs 8'h00, 8'hFF, 8'h01, 8'h80 at period 22'd4096 → each decoded correctly. `ID_vld` is cleared with `clr_ID_vld` between frames.
- **Jitter sweep**: periods 22'd64, 22'd500, 22'd70000, with 20 random IDs each and ±P/32 variation active → 100% match.
- **Clear/set collision**: `clr_ID_vld` asserted in the same cycle as the 8th sample → `ID_vld` = 1.
- **Mid-frame reset**: assert `rst_n` low after 3 bits of 8'h3C → `ID` = 8'h00, `ID_vld` = 0. A following frame 8'h3C then decodes correctly.
- **Truncated frame** (with `BC_RX_TIMEOUT_EN`): stop BC after 4 bits, period 22'd1024 → one `BC_err` pulse ≈2048 clk after the last fall, return to IDLE, `ID` unchanged.
